// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_sequencer
//  Description : Control FSM for a multicycle RV32I core. Steers the shared
//                ALU (operand selects, ADD/decoded function), the PC/IR/
//                branch-target/register-file write strobes and the memory
//                request handshakes, and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          instr,
    input  logic                 br_cond,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic                 tgt_we,
    output logic [1:0]           alu_src1,
    output logic [1:0]           alu_src2,
    output logic                 alu_func_sel,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret,
    output logic                 halted,
    output logic [2:0]           state
);

    // ------------------------------------------------------------------------
    // Opcodes recognised by the sequencer
    // ------------------------------------------------------------------------
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;

    // Select encodings
    localparam logic [1:0] c_SRC1_RS1    = 2'd0;
    localparam logic [1:0] c_SRC1_PC     = 2'd1;
    localparam logic [1:0] c_SRC1_OLDPC  = 2'd2;
    localparam logic [1:0] c_SRC1_ZERO   = 2'd3;
    localparam logic [1:0] c_SRC2_RS2    = 2'd0;
    localparam logic [1:0] c_SRC2_IMM    = 2'd1;
    localparam logic [1:0] c_SRC2_FOUR   = 2'd2;
    localparam logic [1:0] c_PCSRC_ALU   = 2'd0;
    localparam logic [1:0] c_PCSRC_TGT   = 2'd1;
    localparam logic [1:0] c_PCSRC_ALU0  = 2'd2;
    localparam logic [1:0] c_WB_ALU      = 2'd0;
    localparam logic [1:0] c_WB_LOAD     = 2'd1;
    localparam logic [1:0] c_WB_PC       = 2'd2;

    localparam logic [INSTRET_W-1:0] c_INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [INSTRET_W-1:0]   instret_q;
    logic [INSTRET_W-1:0]   instret_d;

    logic [6:0]             w_opcode;
    logic                   w_is_load;
    logic                   w_is_store;
    logic                   w_unused_instr;

    assign w_opcode       = instr[6:0];
    assign w_is_load      = (w_opcode == c_OP_LOAD);
    assign w_is_store     = (w_opcode == c_OP_STORE);
    // Only the opcode field matters to sequencing; the rest goes to the datapath
    assign w_unused_instr = ^instr[31:7];

    assign state   = state_q;
    assign instret = instret_q;

    // State and retired-count registers; reset aborts any access in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Retired-instruction counter, wraps naturally at all-ones
    always_comb begin
        instret_d = instret_q;
        if (retire) begin
            instret_d = instret_q + c_INSTRET_ONE;
        end
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        state_d      = state_q;
        imem_req     = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = c_PCSRC_ALU;
        tgt_we       = 1'b0;
        alu_src1     = c_SRC1_RS1;
        alu_src2     = c_SRC2_RS2;
        alu_func_sel = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = c_WB_ALU;
        retire       = 1'b0;
        halted       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                // ALU forms PC+4 while the fetch is outstanding
                imem_req = 1'b1;
                alu_src1 = c_SRC1_PC;
                alu_src2 = c_SRC2_FOUR;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_src  = c_PCSRC_ALU;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                // Speculative branch/jump target: old PC + imm
                tgt_we   = 1'b1;
                alu_src1 = c_SRC1_OLDPC;
                alu_src2 = c_SRC2_IMM;
                state_d  = S_EXEC;
            end

            S_EXEC: begin
                case (w_opcode)
                    c_OP_R: begin
                        alu_func_sel = 1'b1;
                        state_d      = S_WB;
                    end
                    c_OP_I: begin
                        alu_src2     = c_SRC2_IMM;
                        alu_func_sel = 1'b1;
                        state_d      = S_WB;
                    end
                    c_OP_LOAD, c_OP_STORE: begin
                        alu_src2 = c_SRC2_IMM;
                        state_d  = S_MEM;
                    end
                    c_OP_BR: begin
                        alu_func_sel = 1'b1;
                        if (br_cond) begin
                            pc_we  = 1'b1;
                            pc_src = c_PCSRC_TGT;
                        end
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    c_OP_LUI: begin
                        alu_src1 = c_SRC1_ZERO;
                        alu_src2 = c_SRC2_IMM;
                        state_d  = S_WB;
                    end
                    c_OP_AUIPC: begin
                        alu_src1 = c_SRC1_OLDPC;
                        alu_src2 = c_SRC2_IMM;
                        state_d  = S_WB;
                    end
                    c_OP_JAL: begin
                        // Link value is the PC before this edge (old PC + 4)
                        rf_we   = 1'b1;
                        wb_sel  = c_WB_PC;
                        pc_we   = 1'b1;
                        pc_src  = c_PCSRC_TGT;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    c_OP_JALR: begin
                        alu_src2 = c_SRC2_IMM;
                        rf_we    = 1'b1;
                        wb_sel   = c_WB_PC;
                        pc_we    = 1'b1;
                        pc_src   = c_PCSRC_ALU0;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: begin
                        state_d = S_HALT;
                    end
                endcase
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                if (dmem_ready) begin
                    if (w_is_store) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end

            S_WB: begin
                rf_we   = 1'b1;
                wb_sel  = w_is_load ? c_WB_LOAD : c_WB_ALU;
                retire  = 1'b1;
                state_d = S_FETCH;
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_sequencer
//  Description : Randomized self-checking bench for multicycle_sequencer.
//                Per-instruction expectations (latency, strobe counts,
//                selects, retire count) come from an instruction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] instr;
    logic        br_cond;
    logic        imem_ready;
    logic        dmem_ready;

    logic        imem_req, ir_we, pc_we, tgt_we, alu_func_sel;
    logic        dmem_req, dmem_we, rf_we, retire, halted;
    logic [1:0]  pc_src, alu_src1, alu_src2, wb_sel;
    logic [31:0] instret;
    logic [2:0]  state;

    // Narrow-counter instance used for wrap-around checking
    logic        n_imem_req, n_ir_we, n_pc_we, n_tgt_we, n_alu_func_sel;
    logic        n_dmem_req, n_dmem_we, n_rf_we, n_retire, n_halted;
    logic [1:0]  n_pc_src, n_alu_src1, n_alu_src2, n_wb_sel;
    logic [3:0]  n_instret;
    logic [2:0]  n_state;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_cnt = '0;

    multicycle_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .br_cond(br_cond),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .tgt_we(tgt_we), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_func_sel(alu_func_sel), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .wb_sel(wb_sel), .retire(retire), .instret(instret),
        .halted(halted), .state(state)
    );

    multicycle_sequencer #(.INSTRET_W(4)) dut_w4 (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .br_cond(br_cond),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(n_imem_req), .ir_we(n_ir_we), .pc_we(n_pc_we), .pc_src(n_pc_src),
        .tgt_we(n_tgt_we), .alu_src1(n_alu_src1), .alu_src2(n_alu_src2),
        .alu_func_sel(n_alu_func_sel), .dmem_req(n_dmem_req), .dmem_we(n_dmem_we),
        .rf_we(n_rf_we), .wb_sel(n_wb_sel), .retire(n_retire), .instret(n_instret),
        .halted(n_halted), .state(n_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; leaves it at cycle 0 of FETCH
    task automatic start_pulse();
        start = 1'b1;
        #1;
        chk("idle_state", {29'd0, state}, 32'd0);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset_checks();
        rst = 1'b1;
        #1;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_instret_w4", {28'd0, n_instret}, 32'd0);
        model_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        start_pulse();
    endtask

    // Runs one instruction starting at cycle 0 of FETCH
    task automatic run_instr(input logic [31:0] ins, input logic brc,
                             input int iw, input int dw, input bit abort_mem);
        logic [6:0] op;
        int  lat, xsrc, exp_wb, exp_rfst;
        bit  legal, is_mem, is_st, wr, done;
        logic [1:0] e1, e2;
        logic ef;
        int  c_imem, c_ir, c_tgt, c_pc, c_rf, c_dm, c_dw, c_ret, ret_cyc, end_cyc;
        logic [1:0] last_src, rf_ws, s1, s2;
        logic [2:0] rf_st;
        logic sf;

        op = ins[6:0];
        legal = 1; is_mem = 0; is_st = 0; wr = 0; xsrc = 0; exp_wb = 0; exp_rfst = 5;
        e1 = 0; e2 = 0; ef = 0; lat = 0;
        case (op)
            7'h33: begin lat = 4; wr = 1; ef = 1; end
            7'h13: begin lat = 4; wr = 1; e2 = 1; ef = 1; end
            7'h03: begin lat = 5 + dw; wr = 1; is_mem = 1; e2 = 1; exp_wb = 1; end
            7'h23: begin lat = 4 + dw; is_mem = 1; is_st = 1; e2 = 1; end
            7'h63: begin lat = 3; ef = 1; xsrc = brc ? 1 : 0; end
            7'h37: begin lat = 4; wr = 1; e1 = 3; e2 = 1; end
            7'h17: begin lat = 4; wr = 1; e1 = 2; e2 = 1; end
            7'h6F: begin lat = 3; wr = 1; xsrc = 1; exp_wb = 2; exp_rfst = 3; end
            7'h67: begin lat = 3; wr = 1; e2 = 1; xsrc = 2; exp_wb = 2; exp_rfst = 3; end
            default: legal = 0;
        endcase
        lat += iw;

        c_imem = 0; c_ir = 0; c_tgt = 0; c_pc = 0; c_rf = 0; c_dm = 0; c_dw = 0;
        c_ret = 0; ret_cyc = -1; end_cyc = -1; done = 0;
        last_src = 0; rf_ws = 0; rf_st = 0; s1 = 0; s2 = 0; sf = 0;
        instr = ins;
        br_cond = brc;

        for (int cyc = 0; cyc < 80; cyc++) begin
            imem_ready = (cyc >= iw);
            dmem_ready = (cyc >= iw + 3 + dw);
            #1;
            if (cyc == 0) begin
                chk("fetch_state", {29'd0, state}, 32'd1);
                chk("fetch_sel", {26'd0, alu_src1, alu_src2, 1'b0, alu_func_sel}, {26'd0, 2'd1, 2'd2, 2'd0});
                chk("instret", instret, model_cnt);
                chk("instret_w4", {28'd0, n_instret}, {28'd0, model_cnt[3:0]});
                chk("w4_state", {29'd0, n_state}, {29'd0, state});
            end
            if (state == 3'd2) begin
                chk("decode_sel", {25'd0, tgt_we, alu_src1, alu_src2, 1'b0, alu_func_sel}, {25'd0, 1'b1, 2'd2, 2'd1, 2'd0});
            end
            if (imem_req) c_imem++;
            if (ir_we) c_ir++;
            if (tgt_we) c_tgt++;
            if (pc_we) begin c_pc++; last_src = pc_src; end
            if (rf_we) begin c_rf++; rf_st = state; rf_ws = wb_sel; end
            if (dmem_req) begin c_dm++; if (dmem_we) c_dw++; end
            if (retire) begin c_ret++; ret_cyc = cyc; end
            if (state == 3'd3) begin s1 = alu_src1; s2 = alu_src2; sf = alu_func_sel; end
            if (abort_mem && state == 3'd4) begin
                chk("abort_pre_dmem_req", {31'd0, dmem_req}, 32'd1);
                do_reset_checks();
                return;
            end
            if (retire || state == 3'd6) begin
                end_cyc = cyc;
                done = 1;
                break;
            end
            @(negedge clk);
        end

        if (!done) begin
            chk("timeout", 32'd0, 32'd1);
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $fatal(1, "sequencer stalled");
        end

        chk("imem_req_cycles", c_imem, iw + 1);
        chk("ir_we_count", c_ir, 1);
        chk("tgt_we_count", c_tgt, 1);
        chk("exec_sel", {27'd0, s1, s2, sf}, {27'd0, e1, e2, ef});

        if (legal) begin
            chk("latency", ret_cyc + 1, lat);
            chk("retire_count", c_ret, 1);
            chk("pc_we_count", c_pc, (xsrc != 0) ? 2 : 1);
            chk("pc_src_last", {30'd0, last_src}, xsrc);
            chk("rf_we_count", c_rf, wr ? 1 : 0);
            if (wr) begin
                chk("rf_state", {29'd0, rf_st}, exp_rfst);
                chk("wb_sel", {30'd0, rf_ws}, exp_wb);
            end
            chk("dmem_req_cycles", c_dm, is_mem ? dw + 1 : 0);
            chk("dmem_we_cycles", c_dw, is_st ? dw + 1 : 0);
            model_cnt = model_cnt + 32'd1;
            @(negedge clk);
        end else begin
            chk("halt_cycle", end_cyc, iw + 3);
            chk("halt_flag", {31'd0, halted}, 32'd1);
            chk("halt_no_retire", c_ret + c_rf + c_dm, 0);
            chk("halt_pc_we", c_pc, 1);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                start = ~start;
                #1;
                chk("halt_sticky_state", {29'd0, state}, 32'd6);
                chk("halt_sticky_flag", {31'd0, halted}, 32'd1);
                chk("halt_instret", instret, model_cnt);
            end
            start = 1'b0;
            do_reset_checks();
        end
    endtask

    logic [6:0] legal_ops [9];
    logic [6:0] bad_ops [4];

    initial begin
        legal_ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
        bad_ops   = '{7'h7F, 7'h00, 7'h0F, 7'h73};
        rst = 1'b1; start = 1'b0; instr = '0; br_cond = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_strobes", {23'd0, imem_req, ir_we, pc_we, tgt_we, dmem_req, dmem_we, rf_we, retire, halted}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_hold", {29'd0, state}, 32'd0);
        @(negedge clk);
        start_pulse();

        // Directed cases
        run_instr(32'h00500093, 1'b0, 0, 0, 0);   // ADDI
        run_instr(32'h0000A103, 1'b0, 0, 2, 0);   // LW, two data wait cycles
        run_instr(32'h00000463, 1'b1, 0, 0, 0);   // BEQ taken
        run_instr(32'h00000463, 1'b0, 0, 0, 0);   // BEQ not taken
        run_instr(32'h000080E7, 1'b0, 0, 0, 0);   // JALR
        run_instr(32'h0080006F, 1'b0, 1, 0, 0);   // JAL with fetch wait
        run_instr(32'h0020A023, 1'b0, 0, 5, 1);   // SW aborted by reset in MEM
        run_instr(32'h0000007F, 1'b0, 0, 0, 0);   // illegal opcode

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            logic [31:0] r;
            logic [6:0]  op;
            r = $urandom;
            if ($urandom_range(0, 19) == 0) op = bad_ops[$urandom_range(0, 3)];
            else                            op = legal_ops[$urandom_range(0, 8)];
            run_instr({r[31:7], op}, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2),
                      ($urandom_range(0, 29) == 0));
        end

        #1;
        chk("final_instret", instret, model_cnt);
        chk("final_instret_w4", {28'd0, n_instret}, {28'd0, model_cnt[3:0]});
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
